// File: rtl/cpu_pkg.sv
// Shared CPU constants and types: register-index width, the zero register
// and the pending-write scoreboard sizing.
package cpu_pkg;

  localparam int unsigned NREG     = 32;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned PEND_W   = 2;
  localparam int unsigned PEND_MAX = 3;

  typedef logic [REG_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/sb_pend_cnt.sv
// Saturating pending-write counter for one architectural register. It holds
// on overflow, clamps at zero on underflow and flags both as a one-cycle error pulse.
module sb_pend_cnt #(
  parameter int unsigned CNTW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  input  logic            dec,
  input  logic            kil,
  output logic [CNTW-1:0] cnt,
  output logic            err_c
);

  // Two extra bits: the sum spans -2 .. 2**CNTW, so it needs a sign bit
  // and one bit of headroom.
  localparam int unsigned SW = CNTW + 2;
  localparam logic signed [SW-1:0] CNT_MAX = SW'((2 ** CNTW) - 1);

  logic signed [SW-1:0] sum;
  logic [CNTW-1:0]      cnt_nxt;

  always_comb begin
    sum     = $signed(SW'(cnt)) + $signed(SW'(inc)) - $signed(SW'(dec)) - $signed(SW'(kil));
    cnt_nxt = cnt;
    err_c   = 1'b0;
    if (sum > CNT_MAX) begin
      err_c = 1'b1;
    end else if (sum < $signed(SW'(0))) begin
      cnt_nxt = '0;
      err_c   = 1'b1;
    end else begin
      cnt_nxt = CNTW'(sum);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_nxt;
  end

endmodule

// File: rtl/id_regfile_sb.sv
// Decode-stage register file with WB bypass and a per-register pending-write
// scoreboard that stalls ID while a source operand is still in flight.
module id_regfile_sb #(
  parameter int unsigned NREG = cpu_pkg::NREG,
  parameter int unsigned DW   = 32,
  parameter int unsigned CNTW = cpu_pkg::PEND_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [cpu_pkg::REG_W-1:0] id_rs,
  input  logic [cpu_pkg::REG_W-1:0] id_rt,
  input  logic                     id_rs_used,
  input  logic                     id_rt_used,
  input  logic                     id_issue,
  input  logic                     id_wreg,
  input  logic [cpu_pkg::REG_W-1:0] id_destR,
  input  logic                     kill_valid,
  input  logic [cpu_pkg::REG_W-1:0] kill_destR,
  input  logic                     wb_wreg,
  input  logic [cpu_pkg::REG_W-1:0] wb_destR,
  input  logic [DW-1:0]            wb_dest,
  output logic [DW-1:0]            id_rsdata,
  output logic [DW-1:0]            id_rtdata,
  output logic                     id_stall,
  output logic                     sb_busy,
  output logic                     sb_err
);

  import cpu_pkg::*;

  logic [DW-1:0]                rf [NREG];
  logic [NREG-1:0][CNTW-1:0]    pend;
  logic [NREG-1:0]              cnt_err;
  logic                         rs_haz;
  logic                         rt_haz;
  logic                         issue_ok;
  logic                         issue_err;

  // Operand read with same-cycle WB bypass; r0 reads as zero.
  always_comb begin
    id_rsdata = '0;
    id_rtdata = '0;
    if (id_rs != REG_ZERO)
      id_rsdata = (wb_wreg && wb_destR == id_rs) ? wb_dest : rf[id_rs];
    if (id_rt != REG_ZERO)
      id_rtdata = (wb_wreg && wb_destR == id_rt) ? wb_dest : rf[id_rt];
  end

  // A source retiring this very cycle no longer counts as pending.
  always_comb begin
    rs_haz    = id_rs_used && (id_rs != REG_ZERO) &&
                (pend[id_rs] > CNTW'(wb_wreg && wb_destR == id_rs));
    rt_haz    = id_rt_used && (id_rt != REG_ZERO) &&
                (pend[id_rt] > CNTW'(wb_wreg && wb_destR == id_rt));
    id_stall  = rs_haz | rt_haz;
    issue_ok  = id_issue & ~id_stall;
    issue_err = id_issue & id_stall;
  end

  assign pend[0]    = '0;
  assign cnt_err[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    sb_pend_cnt #(.CNTW(CNTW)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (issue_ok & id_wreg & (id_destR == REG_W'(r))),
      .dec   (wb_wreg & (wb_destR == REG_W'(r))),
      .kil   (kill_valid & (kill_destR == REG_W'(r))),
      .cnt   (pend[r]),
      .err_c (cnt_err[r])
    );
  end

  assign sb_busy = |pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wb_wreg && wb_destR != REG_ZERO) begin
      rf[wb_destR] <= wb_dest;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                          sb_err <= 1'b0;
    else if (issue_err || |cnt_err)   sb_err <= 1'b1;
  end

endmodule

// File: tb/tb_id_regfile_sb.sv
// Self-checking bench for id_regfile_sb: directed vector table followed by
// randomized traffic checked against an array-based reference model.
module tb_id_regfile_sb;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs, id_rt, id_destR, kill_destR, wb_destR;
  logic        id_rs_used, id_rt_used, id_issue, id_wreg, kill_valid, wb_wreg;
  logic [31:0] wb_dest, id_rsdata, id_rtdata;
  logic        id_stall, sb_busy, sb_err;

  id_regfile_sb dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_issue(id_issue), .id_wreg(id_wreg), .id_destR(id_destR),
    .kill_valid(kill_valid), .kill_destR(kill_destR),
    .wb_wreg(wb_wreg), .wb_destR(wb_destR), .wb_dest(wb_dest),
    .id_rsdata(id_rsdata), .id_rtdata(id_rtdata),
    .id_stall(id_stall), .sb_busy(sb_busy), .sb_err(sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rst; logic [4:0] rs, rt; logic rsu, rtu, iss, wreg; logic [4:0] dst;
    logic kv; logic [4:0] kd; logic wbw; logic [4:0] wbd; logic [31:0] wdat;
    logic [31:0] ers, ert; logic est, ebusy, eerr;
  } vec_t;

  int nchk = 0;
  int nerr = 0;

  logic [31:0] mrf [32];
  int          mpend [32];
  bit          merr;

  function automatic vec_t mk(
    input logic r, input logic [4:0] rs_, input logic [4:0] rt_, input logic rsu, input logic rtu,
    input logic iss, input logic wr, input logic [4:0] dst, input logic kv, input logic [4:0] kd,
    input logic wbw, input logic [4:0] wbd, input logic [31:0] wdat,
    input logic [31:0] ers, input logic [31:0] ert, input logic est, input logic ebusy, input logic eerr);
    vec_t v;
    v.rst = r; v.rs = rs_; v.rt = rt_; v.rsu = rsu; v.rtu = rtu; v.iss = iss; v.wreg = wr;
    v.dst = dst; v.kv = kv; v.kd = kd; v.wbw = wbw; v.wbd = wbd; v.wdat = wdat;
    v.ers = ers; v.ert = ert; v.est = est; v.ebusy = ebusy; v.eerr = eerr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: reads and hazards straight from the register/count arrays.
  function automatic logic [31:0] m_rd(input logic [4:0] idx);
    if (idx == 0) return 32'h0;
    if (wb_wreg && wb_destR == idx) return wb_dest;
    return mrf[idx];
  endfunction

  function automatic bit m_haz(input logic [4:0] s, input logic u);
    int d;
    d = (wb_wreg && wb_destR == s) ? 1 : 0;
    return u && (s != 0) && (mpend[s] - d > 0);
  endfunction

  function automatic bit m_busy();
    for (int r = 0; r < 32; r++) if (mpend[r] != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_reset();
    for (int r = 0; r < 32; r++) begin mrf[r] = 32'h0; mpend[r] = 0; end
    merr = 1'b0;
  endtask

  task automatic m_update();
    bit st;
    int n;
    st = m_haz(id_rs, id_rs_used) | m_haz(id_rt, id_rt_used);
    if (rst) begin
      m_reset();
    end else begin
      if (id_issue && st) merr = 1'b1;
      for (int r = 1; r < 32; r++) begin
        n = mpend[r];
        if (id_issue && id_wreg && !st && id_destR == r) n = n + 1;
        if (wb_wreg && wb_destR == r) n = n - 1;
        if (kill_valid && kill_destR == r) n = n - 1;
        if (n > 3) merr = 1'b1;
        else if (n < 0) begin mpend[r] = 0; merr = 1'b1; end
        else mpend[r] = n;
      end
      if (wb_wreg && wb_destR != 0) mrf[wb_destR] = wb_dest;
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; id_rs = v.rs; id_rt = v.rt; id_rs_used = v.rsu; id_rt_used = v.rtu;
    id_issue = v.iss; id_wreg = v.wreg; id_destR = v.dst; kill_valid = v.kv; kill_destR = v.kd;
    wb_wreg = v.wbw; wb_destR = v.wbd; wb_dest = v.wdat;
  endtask

  // One cycle: drive after negedge, check before posedge, then advance the model.
  task automatic cycle(input vec_t v, input bit tbl, input string tag);
    drive(v);
    #1;
    if (tbl) begin
      chk({tag, " rsdata"}, id_rsdata, v.ers);
      chk({tag, " rtdata"}, id_rtdata, v.ert);
      chk({tag, " stall"},  32'(id_stall), 32'(v.est));
      chk({tag, " busy"},   32'(sb_busy),  32'(v.ebusy));
      chk({tag, " err"},    32'(sb_err),   32'(v.eerr));
    end else begin
      chk({tag, " rsdata"}, id_rsdata, m_rd(id_rs));
      chk({tag, " rtdata"}, id_rtdata, m_rd(id_rt));
      chk({tag, " stall"},  32'(id_stall), 32'(m_haz(id_rs, id_rs_used) | m_haz(id_rt, id_rt_used)));
      chk({tag, " busy"},   32'(sb_busy),  32'(m_busy()));
      chk({tag, " err"},    32'(sb_err),   32'(merr));
    end
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  function automatic int pick_pend();
    int s;
    s = $urandom_range(0, 7);
    for (int k = 0; k < 8; k++) if (mpend[(s + k) % 8] > 0) return (s + k) % 8;
    return -1;
  endfunction

  vec_t tbl [$];
  vec_t rv;
  int   p;

  initial begin
    m_reset();
    drive(mk(1,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0));
    @(negedge clk); @(negedge clk); @(negedge clk);

    //          rst rs rt rsu rtu iss wr dst kv kd wbw wbd wdat          ers           ert    st bsy err
    tbl.push_back(mk(0, 0, 0,0,0, 0,0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,  0,0,0));
    tbl.push_back(mk(0, 0, 0,0,0, 1,1, 5, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,  0,0,0));
    tbl.push_back(mk(0, 5, 0,1,0, 0,0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,  1,1,0));
    tbl.push_back(mk(0, 5, 0,1,0, 0,0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,  0,1,0));
    tbl.push_back(mk(0, 5, 0,1,0, 0,0, 0, 0, 0, 0, 0, 32'h0,        32'hDEADBEEF, 32'h0,  0,0,0));
    tbl.push_back(mk(0, 0, 0,0,0, 1,1, 3, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,  0,0,0));
    tbl.push_back(mk(0, 3, 0,1,0, 0,0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,  1,1,0));
    tbl.push_back(mk(0, 3, 0,1,0, 0,0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,  1,1,0));
    tbl.push_back(mk(0, 3, 0,1,0, 0,0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,  1,1,0));
    tbl.push_back(mk(0, 3, 0,1,0, 1,0, 0, 0, 0, 1, 3, 32'h33,       32'h33,       32'h0,  0,1,0));
    tbl.push_back(mk(0, 3, 0,1,0, 0,0, 0, 0, 0, 0, 0, 32'h0,        32'h33,       32'h0,  0,0,0));
    tbl.push_back(mk(0, 0, 0,0,0, 1,1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,  0,0,0));
    tbl.push_back(mk(0, 0, 0,1,0, 1,1, 7, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,  0,0,0));
    tbl.push_back(mk(0, 0, 7,0,0, 0,0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,  0,1,0));
    tbl.push_back(mk(0, 0, 7,0,1, 0,0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,  1,1,0));
    tbl.push_back(mk(0, 0, 7,0,1, 0,0, 0, 0, 0, 1, 7, 32'h77,       32'h0,        32'h77, 0,1,0));
    tbl.push_back(mk(0, 0, 7,0,1, 1,1, 9, 0, 0, 0, 0, 32'h0,        32'h0,        32'h77, 0,0,0));
    tbl.push_back(mk(0, 0, 0,0,0, 1,1, 9, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,  0,1,0));
    tbl.push_back(mk(0, 9, 0,1,0, 0,0, 0, 1, 9, 0, 0, 32'h0,        32'h0,        32'h0,  1,1,0));
    tbl.push_back(mk(0, 9, 0,1,0, 0,0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,  1,1,0));
    tbl.push_back(mk(0, 9, 0,1,0, 0,0, 0, 0, 0, 1, 9, 32'h99,       32'h99,       32'h0,  0,1,0));
    tbl.push_back(mk(0, 9, 0,1,0, 0,0, 0, 0, 0, 0, 0, 32'h0,        32'h99,       32'h0,  0,0,0));
    tbl.push_back(mk(0, 4, 0,1,0, 0,0, 0, 0, 0, 1, 4, 32'h44,       32'h44,       32'h0,  0,0,0));
    tbl.push_back(mk(0, 4, 0,1,0, 0,0, 0, 0, 0, 0, 0, 32'h0,        32'h44,       32'h0,  0,0,1));
    tbl.push_back(mk(1, 4, 0,1,0, 0,0, 0, 0, 0, 0, 0, 32'h0,        32'h44,       32'h0,  0,0,1));
    tbl.push_back(mk(0, 4, 0,1,0, 0,0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,  0,0,0));
    tbl.push_back(mk(0, 0, 0,0,0, 1,1, 6, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,  0,0,0));
    tbl.push_back(mk(0, 6, 0,1,0, 1,1,10, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,  1,1,0));
    tbl.push_back(mk(0,10, 0,1,0, 0,0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,  0,1,1));
    tbl.push_back(mk(1, 0, 0,0,0, 0,0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,  0,1,1));
    tbl.push_back(mk(0, 0, 0,0,0, 0,0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,  0,0,0));
    tbl.push_back(mk(0, 0, 0,0,0, 1,1,11, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,  0,0,0));
    tbl.push_back(mk(0, 0, 0,0,0, 1,1,11, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,  0,1,0));
    tbl.push_back(mk(0, 0, 0,0,0, 1,1,11, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,  0,1,0));
    tbl.push_back(mk(0, 0, 0,0,0, 1,1,11, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,  0,1,0));
    tbl.push_back(mk(0,11, 0,1,0, 0,0, 0, 0, 0, 1,11, 32'hB1,       32'hB1,       32'h0,  1,1,1));
    tbl.push_back(mk(0,11, 0,1,0, 0,0, 0, 0, 0, 1,11, 32'hB2,       32'hB2,       32'h0,  1,1,1));
    tbl.push_back(mk(0,11, 0,1,0, 0,0, 0, 0, 0, 1,11, 32'hB3,       32'hB3,       32'h0,  0,1,1));
    tbl.push_back(mk(0,11, 0,1,0, 0,0, 0, 0, 0, 0, 0, 32'h0,        32'hB3,       32'h0,  0,0,1));
    tbl.push_back(mk(0, 0, 0,0,0, 1,1,12, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,  0,0,1));
    tbl.push_back(mk(0, 0, 0,0,0, 1,1,13, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,  0,1,1));
    tbl.push_back(mk(1,12,13,1,1, 1,1,14, 1,13, 1,12, 32'hC,        32'hC,        32'h0,  1,1,1));
    tbl.push_back(mk(0,12,14,1,1, 0,0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,  0,0,0));

    for (int i = 0; i < tbl.size(); i++) cycle(tbl[i], 1'b1, $sformatf("vec%0d", i));

    // Randomized traffic on r0..r7 so issues, kills and write-backs collide often.
    for (int i = 0; i < 800; i++) begin
      rv = mk(0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0);
      rv.rst  = ($urandom_range(0, 63) == 0);
      rv.rs   = 5'($urandom_range(0, 7));
      rv.rt   = 5'($urandom_range(0, 7));
      rv.rsu  = 1'($urandom_range(0, 1));
      rv.rtu  = 1'($urandom_range(0, 1));
      rv.iss  = ($urandom_range(0, 1) == 1);
      rv.wreg = ($urandom_range(0, 3) != 0);
      rv.dst  = 5'($urandom_range(0, 7));
      p = pick_pend();
      if ($urandom_range(0, 9) == 0 && p >= 0) begin
        rv.kv = 1'b1; rv.kd = 5'(p);
      end
      if ($urandom_range(0, 9) < 6) begin
        rv.wbw = 1'b1;
        p = pick_pend();
        rv.wbd = (p >= 0 && $urandom_range(0, 19) != 0) ? 5'(p) : 5'($urandom_range(0, 7));
        rv.wdat = $urandom;
      end
      cycle(rv, 1'b0, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
